// File: rtl/store_buffer_if.sv
// Core-side and dmem-side signal bundle for the store buffer.
// slave is the buffer's view; master is the core/dmem side.
interface store_buffer_if #(
   parameter int AW    = 6,
   parameter int DEPTH = 4
);
   logic                   we_in;
   logic                   re_in;
   logic [AW-1:0]          addr_in;
   logic [31:0]            wd_in;
   logic                   stall_out;
   logic [31:0]            rd_out;
   logic                   mem_we;
   logic [AW-1:0]          mem_a;
   logic [31:0]            mem_d;
   logic [31:0]            mem_q;
   logic                   mem_ready;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;

   modport slave (
      input  we_in, re_in, addr_in, wd_in, mem_q, mem_ready,
      output stall_out, rd_out, mem_we, mem_a, mem_d, empty, count
   );

   modport master (
      output we_in, re_in, addr_in, wd_in, mem_q, mem_ready,
      input  stall_out, rd_out, mem_we, mem_a, mem_d, empty, count
   );
endinterface

// File: rtl/store_buffer.sv
// M-stage store buffer: circular FIFO of pending stores drained to dmem
// when the port is free, with youngest-match load forwarding.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 6
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          full;
   logic          drain;
   logic          stall;
   logic          push;
   logic          hit;
   logic [31:0]   fwd_data;
   logic [PW-1:0] idx;

   always_comb begin
      full  = (count_q == CW'(DEPTH));
      drain = !rst && (count_q != '0) && !sb.re_in && sb.mem_ready;
      stall = !rst && sb.we_in && full && !drain;
      push  = !rst && sb.we_in && !stall;

      sb.stall_out = stall;
      sb.mem_we    = drain;
      sb.mem_a     = drain ? addr_q[head_q] : sb.addr_in;
      sb.mem_d     = drain ? data_q[head_q] : 32'd0;

      // Walk oldest to youngest so the last match is the youngest.
      hit      = 1'b0;
      fwd_data = 32'd0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == sb.addr_in)) begin
            hit      = 1'b1;
            fwd_data = data_q[idx];
         end
      end

      if (rst || !sb.re_in) sb.rd_out = 32'd0;
      else if (hit)         sb.rd_out = fwd_data;
      else                  sb.rd_out = sb.mem_q;

      sb.empty = rst || (count_q == '0);
      sb.count = rst ? '0 : count_q;

      addr_d = addr_q;
      data_d = data_q;
      if (push) begin
         addr_d[tail_q] = sb.addr_in;
         data_d[tail_q] = sb.wd_in;
      end

      head_d = drain ? head_q + PW'(1) : head_q;
      tail_d = push  ? tail_q + PW'(1) : tail_q;

      unique case ({push, drain})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
      addr_q <= addr_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based model
// of the pending-store list and the dmem port behaviour.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 6;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } ent_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   ent_t q[$];

   store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) sb_if ();

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic          r,
                       input logic          w,
                       input logic          rd,
                       input logic [AW-1:0] a,
                       input logic [31:0]   wd,
                       input logic [31:0]   mq,
                       input logic          rdy);
      logic        e_drain;
      logic        e_stall;
      logic [31:0] e_rd;
      logic [31:0] e_ma;
      logic [31:0] e_md;
      @(negedge clk);
      rst             = r;
      sb_if.we_in     = w;
      sb_if.re_in     = rd;
      sb_if.addr_in   = a;
      sb_if.wd_in     = wd;
      sb_if.mem_q     = mq;
      sb_if.mem_ready = rdy;
      #1;
      e_drain = !r && (q.size() > 0) && !rd && rdy;
      e_stall = !r && w && (q.size() == DEPTH) && !e_drain;
      e_rd    = 32'd0;
      if (!r && rd) begin
         e_rd = mq;
         foreach (q[i]) if (q[i].a == a) e_rd = q[i].d;
      end
      e_ma = e_drain ? 32'(q[0].a) : 32'(a);
      e_md = e_drain ? q[0].d : 32'd0;
      check("stall_out", 32'(sb_if.stall_out), 32'(e_stall));
      check("mem_we",    32'(sb_if.mem_we),    32'(e_drain));
      check("mem_a",     32'(sb_if.mem_a),     e_ma);
      check("mem_d",     sb_if.mem_d,          e_md);
      check("rd_out",    sb_if.rd_out,         e_rd);
      check("empty",     32'(sb_if.empty),
            32'(r || (q.size() == 0)));
      check("count",     32'(sb_if.count),
            r ? 32'd0 : 32'(q.size()));
      @(posedge clk);
      if (r) begin
         q.delete();
      end else begin
         if (e_drain) q.delete(0);
         if (w && !e_stall) q.push_back(ent_t'({a, wd}));
      end
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 1'b0, 6'h3f, 32'h0, 32'h5a5a5a5a, rdy);
   endtask

   task automatic store(input logic [AW-1:0] a,
                        input logic [31:0] d,
                        input logic rdy);
      step(1'b0, 1'b1, 1'b0, a, d, 32'h0, rdy);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      sb_if.we_in = 1'b0;
      sb_if.re_in = 1'b0;
      sb_if.addr_in = '0;
      sb_if.wd_in = '0;
      sb_if.mem_q = '0;
      sb_if.mem_ready = 1'b0;

      // reset with busy inputs must still look idle
      step(1'b1, 1'b1, 1'b1, 6'h05, 32'h12345678, 32'h9, 1'b1);
      step(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0);

      // single store then drain
      store(6'h05, 32'hDEADBEEF, 1'b1);
      idle(1'b1, 2);

      // fill, stall, then ordered drain
      for (int k = 1; k <= 4; k++) store(AW'(k), 32'h100 + k, 1'b0);
      store(6'h05, 32'h105, 1'b0);
      store(6'h05, 32'h105, 1'b1);
      idle(1'b1, 5);

      // forwarding youngest match and miss
      store(6'h08, 32'h11111111, 1'b0);
      store(6'h08, 32'h22222222, 1'b0);
      step(1'b0, 1'b0, 1'b1, 6'h08, 32'h0, 32'hFFFF0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 6'h09, 32'h0, 32'hABCD0000, 1'b0);
      idle(1'b1, 3);

      // loads hold off draining
      store(6'h10, 32'hA0, 1'b0);
      store(6'h11, 32'hA1, 1'b0);
      for (int k = 0; k < 3; k++)
         step(1'b0, 1'b0, 1'b1, 6'h20, 32'h0, 32'h77, 1'b1);
      idle(1'b1, 3);

      // full with push and drain together, wrapping tail
      for (int k = 0; k < 4; k++) store(AW'(6'h18 + k), 32'hB0 + k, 1'b0);
      store(6'h1c, 32'hB4, 1'b1);
      store(6'h1d, 32'hB5, 1'b1);
      idle(1'b1, 6);

      // reset discards pending stores
      for (int k = 0; k < 3; k++) store(AW'(6'h30 + k), 32'hC0 + k, 1'b0);
      step(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
      idle(1'b1, 3);

      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0,
              AW'($urandom_range(0, 7)),
              $urandom,
              $urandom,
              $urandom_range(0, 4) < 3);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
